// File: rtl/nco_bank.sv
// Multi-voice NCO bank: VOICES phase accumulators share one quarter-wave sine ROM and mix into a saturated stereo pair.
// Optional feature: define NCO_PHASE_SYNC_EN to add the phase_sync input (realigns all voices to phase 0).
module nco_bank #(
    parameter int BITSIZE   = 24,
    parameter int PHASESIZE = 16,
    parameter int TABLESIZE = 9,
    parameter int VOICES    = 4,
    parameter int AMPSIZE   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lrclk,
    input  logic                        cfg_we,
    input  logic [3:0]                  cfg_addr,
    input  logic [PHASESIZE-1:0]        cfg_freq,
    input  logic [AMPSIZE:0]            cfg_amp,
    input  logic                        cfg_route,
`ifdef NCO_PHASE_SYNC_EN
    input  logic                        phase_sync,
`endif
    output logic signed [BITSIZE-1:0]   left,
    output logic signed [BITSIZE-1:0]   right,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int QW     = TABLESIZE - 2;
    localparam int QN     = 1 << QW;
    localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int NV     = 1 << VW;
    localparam int ACC_W  = BITSIZE + $clog2(VOICES) + 1;
    localparam int PROD_W = BITSIZE + AMPSIZE + 2;
    localparam int PEAK   = (1 << (BITSIZE - 1)) - 1;

    localparam logic [AMPSIZE:0]              AMP_ONE = (AMPSIZE + 1)'(1 << AMPSIZE);
    localparam logic signed [BITSIZE-1:0]     OUT_MAX = BITSIZE'(PEAK);
    localparam logic signed [BITSIZE-1:0]     OUT_MIN = ~OUT_MAX;
    localparam logic signed [ACC_W-1:0]       SAT_HI  = ACC_W'(PEAK);
    localparam logic signed [ACC_W-1:0]       SAT_LO  = ~SAT_HI;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ACC   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic logic signed [BITSIZE-1:0] sine_entry(input int k);
        real x;
        x = real'(PEAK) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << TABLESIZE));
        return BITSIZE'($rtoi(x + 0.5));
    endfunction

    function automatic logic signed [BITSIZE-1:0] saturate(input logic signed [ACC_W-1:0] x);
        if (x > SAT_HI)
            return OUT_MAX;
        else if (x < SAT_LO)
            return OUT_MIN;
        else
            return BITSIZE'(x);
    endfunction

    logic signed [BITSIZE-1:0] rom [QN];
    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam logic signed [BITSIZE-1:0] ENTRY = sine_entry(k);
        assign rom[k] = ENTRY;
    end

    logic                      lr_sync_p0, lr_sync_p1, lr_prev;
    logic                      frame_start, start_go, sync_now, cfg_hit;
    logic [AMPSIZE:0]          amp_clamped;
    logic [1:0]                state;
    logic [VW-1:0]             voice;
    logic [PHASESIZE-1:0]      freq_pend [NV];
    logic [PHASESIZE-1:0]      freq_act  [NV];
    logic [AMPSIZE:0]          amp_pend  [NV];
    logic [AMPSIZE:0]          amp_act   [NV];
    logic                      route_pend[NV];
    logic                      route_act [NV];
    logic [PHASESIZE-1:0]      phase     [NV];

    logic [TABLESIZE-1:0]      idx;
    logic [1:0]                quad;
    logic [QW-1:0]             k_idx, rom_addr;
    logic                      fold_peak;
    logic signed [BITSIZE-1:0] rom_p0;
    logic                      neg_p0;
    logic signed [BITSIZE-1:0] sample_p1;
    logic signed [AMPSIZE+1:0] gain_p1;
    logic signed [PROD_W-1:0]  prod_p1;
    logic signed [ACC_W-1:0]   term_p1, acc_l, acc_r, sum_l, sum_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_sync_p0 <= 1'b0;
            lr_sync_p1 <= 1'b0;
            lr_prev    <= 1'b0;
        end else begin
            lr_sync_p0 <= lrclk;
            lr_sync_p1 <= lr_sync_p0;
            lr_prev    <= lr_sync_p1;
        end
    end

    assign frame_start = lr_sync_p1 & ~lr_prev;
    assign start_go    = frame_start & ~busy;
    assign cfg_hit     = cfg_we && ({1'b0, cfg_addr} < 5'(VOICES));
    assign amp_clamped = (cfg_amp > AMP_ONE) ? AMP_ONE : cfg_amp;

`ifdef NCO_PHASE_SYNC_EN
    logic sync_pend;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_pend <= 1'b0;
        else if (start_go)
            sync_pend <= 1'b0;
        else if (phase_sync)
            sync_pend <= 1'b1;
    end
    assign sync_now = sync_pend | phase_sync;
`else
    assign sync_now = 1'b0;
`endif

    // A write landing in the same cycle as an accepted frame start goes straight into that frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NV; i++) begin
                freq_pend[i]  <= '0;
                amp_pend[i]   <= '0;
                route_pend[i] <= 1'b0;
                freq_act[i]   <= '0;
                amp_act[i]    <= '0;
                route_act[i]  <= 1'b0;
                phase[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (cfg_hit && cfg_addr == 4'(i)) begin
                    freq_pend[i]  <= cfg_freq;
                    amp_pend[i]   <= amp_clamped;
                    route_pend[i] <= cfg_route;
                end
                if (start_go) begin
                    freq_act[i]  <= (cfg_hit && cfg_addr == 4'(i)) ? cfg_freq    : freq_pend[i];
                    amp_act[i]   <= (cfg_hit && cfg_addr == 4'(i)) ? amp_clamped : amp_pend[i];
                    route_act[i] <= (cfg_hit && cfg_addr == 4'(i)) ? cfg_route   : route_pend[i];
                end
                if (start_go && sync_now)
                    phase[i] <= '0;
                else if (state == FETCH && voice == VW'(i))
                    phase[i] <= phase[i] + freq_act[i];
            end
        end
    end

    always_comb begin
        idx       = phase[voice][PHASESIZE-1 -: TABLESIZE];
        quad      = idx[TABLESIZE-1 -: 2];
        k_idx     = idx[QW-1:0];
        fold_peak = quad[0] && (k_idx == '0);
        rom_addr  = quad[0] ? (QW'(0) - k_idx) : k_idx;
        sample_p1 = neg_p0 ? -rom_p0 : rom_p0;
        gain_p1   = {1'b0, amp_act[voice]};
        prod_p1   = PROD_W'(sample_p1) * PROD_W'(gain_p1);
        term_p1   = ACC_W'(prod_p1 >>> AMPSIZE);
        sum_l     = acc_l + (route_act[voice] ? '0 : term_p1);
        sum_r     = acc_r + (route_act[voice] ? term_p1 : '0);
    end

    // FETCH -> ACC stage boundary: folded ROM read and quadrant sign
    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            rom_p0 <= fold_peak ? OUT_MAX : rom[rom_addr];
            neg_p0 <= quad[1];
        end
        if (start_go) begin
            acc_l <= '0;
            acc_r <= '0;
        end else if (state == ACC) begin
            acc_l <= sum_l;
            acc_r <= sum_r;
        end
    end

    // Last ACC saturates and registers the outputs so out_valid lands 2*VOICES+1 cycles after the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            voice     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            left      <= '0;
            right     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (frame_start && busy)
                overrun <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (frame_start) begin
                        state <= FETCH;
                        voice <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: state <= ACC;
                ACC: begin
                    if (voice == VW'(VOICES - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        left      <= saturate(sum_l);
                        right     <= saturate(sum_r);
                    end else begin
                        voice <= voice + VW'(1);
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
